// File: rtl/dpram_arbiter_if.sv
// Request/grant bundle between two requesters and the shared-memory arbiter.
// Each requester drives its own _0 or _1 group. The arbiter drives gnt and the read-back signals.
interface dpram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // Handshake: a requester raises req with we/Addr/Wdata and holds them stable
  // until it sees gnt. The access executes in the one gnt-high cycle. The
  // requester drops req the next cycle unless it is issuing a new request.
  // Read data returns as a one-cycle rvalid pulse in the following cycle.
  logic              req_0;
  logic              req_1;
  logic              we_0;
  logic              we_1;
  logic [ADDR_W-1:0] Addr_0;
  logic [ADDR_W-1:0] Addr_1;
  logic [DATA_W-1:0] Wdata_0;
  logic [DATA_W-1:0] Wdata_1;
  logic              gnt_0;
  logic              gnt_1;
  logic [DATA_W-1:0] Rdata_0;
  logic [DATA_W-1:0] Rdata_1;
  logic              rvalid_0;
  logic              rvalid_1;

  modport master (
    output req_0, req_1, we_0, we_1, Addr_0, Addr_1, Wdata_0, Wdata_1,
    input  gnt_0, gnt_1, Rdata_0, Rdata_1, rvalid_0, rvalid_1
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, Addr_0, Addr_1, Wdata_0, Wdata_1,
    output gnt_0, gnt_1, Rdata_0, Rdata_1, rvalid_0, rvalid_1
  );
endinterface

// File: rtl/dpram_arbiter.sv
// Two-requester arbiter in front of one single-port memory (IDLE/GRANT0/GRANT1).
// Define DPRAM_ARB_RR_EN to resolve simultaneous requests round-robin; otherwise port 0 wins ties.
module dpram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  dpram_arbiter_if.slave     bus,
  output logic               busy,
  output logic [7:0]         conflict_cnt,
  output logic [1:0]         state_dbg
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              tie_to_1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_0;
  logic              rd_1;
  logic              waiting;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;
  logic              rvalid_0;
  logic              rvalid_1;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef DPRAM_ARB_RR_EN
  logic last_1;  // 1 = port 1 was served most recently

  always_ff @(posedge clk) begin
    if (rst) begin
      last_1 <= 1'b1;
    end else if (state == GRANT0) begin
      last_1 <= 1'b0;
    end else if (state == GRANT1) begin
      last_1 <= 1'b1;
    end
  end

  assign tie_to_1 = ~last_1;
`else
  assign tie_to_1 = 1'b0;
`endif

  // A port is never granted twice in a row: its own req is ignored while it is granted.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.req_0 && bus.req_1) begin
          state_nxt = tie_to_1 ? GRANT1 : GRANT0;
        end else if (bus.req_0) begin
          state_nxt = GRANT0;
        end else if (bus.req_1) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0:  state_nxt = bus.req_1 ? GRANT1 : IDLE;
      GRANT1:  state_nxt = bus.req_0 ? GRANT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.Addr_0;
    wr_data = bus.Wdata_0;
    if (state == GRANT0) begin
      wr_en = bus.we_0 & ~rst;
    end else if (state == GRANT1) begin
      wr_en   = bus.we_1 & ~rst;
      wr_addr = bus.Addr_1;
      wr_data = bus.Wdata_1;
    end
  end

  assign rd_0    = (state == GRANT0) && !bus.we_0;
  assign rd_1    = (state == GRANT1) && !bus.we_1;
  assign waiting = ((state == GRANT0) && bus.req_1) || ((state == GRANT1) && bus.req_0);

  // Memory contents survive reset; only the commit of a write is suppressed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_0  <= '0;
      rdata_1  <= '0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
    end else begin
      rvalid_0 <= rd_0;
      rvalid_1 <= rd_1;
      if (rd_0) begin
        rdata_0 <= mem[bus.Addr_0];
      end
      if (rd_1) begin
        rdata_1 <= mem[bus.Addr_1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (waiting && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign bus.gnt_0    = (state == GRANT0);
  assign bus.gnt_1    = (state == GRANT1);
  assign bus.Rdata_0  = rdata_0;
  assign bus.Rdata_1  = rdata_1;
  assign bus.rvalid_0 = rvalid_0;
  assign bus.rvalid_1 = rvalid_1;
  assign busy         = (state != IDLE);
  assign conflict_cnt = cnt;
  assign state_dbg    = state;
endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed and randomized checks of dpram_arbiter against a transaction-level model.
// The model tracks who holds the memory each cycle and which reads are owed.
module tb_dpram_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
`ifdef DPRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] conflict_cnt;
  logic [1:0] state_dbg;

  dpram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dpram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .conflict_cnt (conflict_cnt),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int                total = 0;
  int                bad   = 0;
  int                m_g;      // port holding the memory this cycle, -1 when none
  int                m_last;   // port served most recently
  int                m_cnt;
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rdata [2];
  logic              m_rv [2];
  logic [DATA_W-1:0] exp_q0 [$];
  logic [DATA_W-1:0] exp_q1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Effect of the coming clock edge, from the current inputs.
  task automatic model_step();
    int   nxt;
    logic r0;
    logic r1;
    r0 = bus.req_0;
    r1 = bus.req_1;
    if (rst) begin
      m_g = -1; m_last = 1; m_cnt = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_rdata[0] = '0; m_rdata[1] = '0;
      return;
    end
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (m_g == 0) begin
      if (bus.we_0) m_mem[bus.Addr_0] = bus.Wdata_0;
      else begin
        m_rdata[0] = m_mem[bus.Addr_0]; m_rv[0] = 1'b1; exp_q0.push_back(m_rdata[0]);
      end
    end else if (m_g == 1) begin
      if (bus.we_1) m_mem[bus.Addr_1] = bus.Wdata_1;
      else begin
        m_rdata[1] = m_mem[bus.Addr_1]; m_rv[1] = 1'b1; exp_q1.push_back(m_rdata[1]);
      end
    end
    if ((m_g == 0 && r1) || (m_g == 1 && r0)) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (m_g >= 0) m_last = m_g;
    if (m_g == 0)           nxt = r1 ? 1 : -1;
    else if (m_g == 1)      nxt = r0 ? 0 : -1;
    else if (r0 && r1)      nxt = RR ? 1 - m_last : 0;
    else if (r0)            nxt = 0;
    else if (r1)            nxt = 1;
    else                    nxt = -1;
    m_g = nxt;
  endtask

  task automatic check_all();
    check("gnt_0", bus.gnt_0, m_g == 0);
    check("gnt_1", bus.gnt_1, m_g == 1);
    check("busy", busy, m_g != -1);
    check("rvalid_0", bus.rvalid_0, m_rv[0]);
    check("rvalid_1", bus.rvalid_1, m_rv[1]);
    check("rdata_0_hold", bus.Rdata_0, m_rdata[0]);
    check("rdata_1_hold", bus.Rdata_1, m_rdata[1]);
    check("conflict_cnt", conflict_cnt, m_cnt);
    if (bus.rvalid_0) begin
      if (exp_q0.size() > 0) check("sb_rdata_0", bus.Rdata_0, exp_q0.pop_front());
      else check("sb_unexpected_rvalid_0", bus.rvalid_0, 0);
    end
    if (bus.rvalid_1) begin
      if (exp_q1.size() > 0) check("sb_rdata_1", bus.Rdata_1, exp_q1.pop_front());
      else check("sb_unexpected_rvalid_1", bus.rvalid_1, 0);
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.req_0 = req; bus.we_0 = we; bus.Addr_0 = a; bus.Wdata_0 = d;
    end else begin
      bus.req_1 = req; bus.we_1 = we; bus.Addr_1 = a; bus.Wdata_1 = d;
    end
  endtask

  // One complete access on port p: request, wait for grant, finish the grant cycle, release.
  task automatic access(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    set_port(p, 1'b1, we, a, d);
    do begin
      tick();
      n++;
    end while (m_g != p && n < 8);
    check($sformatf("access_gnt_%0d", p), (p == 0) ? bus.gnt_0 : bus.gnt_1, 1);
    tick();
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  int                busy_cycles;
  int                g0_cnt;
  int                g1_cnt;
  int                first;
  logic              r;
  logic [DATA_W-1:0] held;
  int                served [2];

  initial begin
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("rst_gnt_0", bus.gnt_0, 0);
    check("rst_gnt_1", bus.gnt_1, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_rdata_0", bus.Rdata_0, 0);
    check("rst_rvalid_1", bus.rvalid_1, 0);
    check("rst_state_dbg", state_dbg, 0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) access(0, 1'b1, a[ADDR_W-1:0], 8'($urandom_range(0, 255)));

    // write then cross-port read of the same word
    access(0, 1'b1, 4'd3, 8'hA5);
    access(1, 1'b0, 4'd3, 8'h00);
    check("wr_rd_rvalid_1", bus.rvalid_1, 1);
    check("wr_rd_rdata_1", bus.Rdata_1, 8'hA5);

    // reset landing on the grant cycle of a write
    access(0, 1'b1, 4'd5, 8'h11);
    set_port(0, 1'b1, 1'b1, 4'd5, 8'h3C);
    tick();
    check("rstw_gnt_0", bus.gnt_0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    check("rstw_gnt_0_after", bus.gnt_0, 0);
    check("rstw_busy_after", busy, 0);
    check("rstw_rvalid_0_after", bus.rvalid_0, 0);
    check("rstw_cnt_after", conflict_cnt, 0);
    access(1, 1'b0, 4'd5, 8'h00);
    check("rstw_old_data", bus.Rdata_1, 8'h11);

    // simultaneous requests straight after reset
    rst = 1'b1; tick(); rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 4'd3, '0);
    set_port(1, 1'b1, 1'b0, 4'd5, '0);
    busy_cycles = 0;
    tick(); busy_cycles += int'(busy);
    check("tie_first_gnt_0", bus.gnt_0, 1);
    tick(); busy_cycles += int'(busy);
    check("tie_then_gnt_1", bus.gnt_1, 1);
    set_port(0, 1'b0, 1'b0, '0, '0);
    tick(); busy_cycles += int'(busy);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick(); busy_cycles += int'(busy);
    check("tie_conflict_cnt", conflict_cnt, 1);
    check("tie_busy_cycles", busy_cycles, 2);

    // tie after port 0 was the last one served
    access(0, 1'b0, 4'd7, '0);
    set_port(0, 1'b1, 1'b0, 4'd3, '0);
    set_port(1, 1'b1, 1'b0, 4'd5, '0);
    tick();
    first = RR ? 1 : 0;
    check("repeat_tie_winner", {bus.gnt_1, bus.gnt_0}, RR ? 2'b10 : 2'b01);
    tick();
    set_port(first, 1'b0, 1'b0, '0, '0);
    tick();
    set_port(1 - first, 1'b0, 1'b0, '0, '0);
    tick();

    // both ports requesting continuously
    rst = 1'b1; tick(); rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 4'd1, '0);
    set_port(1, 1'b1, 1'b0, 4'd2, '0);
    g0_cnt = 0;
    g1_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      g0_cnt += int'(bus.gnt_0);
      g1_cnt += int'(bus.gnt_1);
    end
    check("cont_cnt_saturated", conflict_cnt, 255);
    check("cont_grants_0", g0_cnt, 150);
    check("cont_grants_1", g1_cnt, 150);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // read then write on the same port: read data must hold
    access(0, 1'b0, 4'd15, '0);
    held = m_mem[15];
    check("hold_read15", bus.Rdata_0, held);
    set_port(0, 1'b1, 1'b1, 4'd0, 8'h5A);
    tick();
    tick();
    set_port(0, 1'b0, 1'b0, '0, '0);
    check("hold_no_rvalid", bus.rvalid_0, 0);
    check("hold_rdata_0", bus.Rdata_0, held);

    // randomized traffic following the request protocol
    served[0] = 0;
    served[1] = 0;
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? bus.req_0 : bus.req_1;
        if (m_g == p) served[p] = 1;
        else if (served[p] != 0 || !r) begin
          served[p] = 0;
          if ($urandom_range(0, 99) < 60)
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 255)));
          else
            set_port(p, 1'b0, 1'b0, '0, '0);
        end
      end
      tick();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    tick();
    check("sb_left_0", exp_q0.size(), 0);
    check("sb_left_1", exp_q1.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
